// File: rtl/fifo.sv
// Single-clock 16x8 FIFO with registered full/empty flags, one-cycle
// overflow/underflow strobes and an occupancy count (modulo DEPTH).
module fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   full,
    output logic                   overflow,
    output logic                   empty,
    output logic                   underflow,
    output logic [COUNT_WIDTH-1:0] data_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [COUNT_WIDTH:0] OCC_FULL = (COUNT_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [COUNT_WIDTH:0]  occ;
    logic [COUNT_WIDTH:0]  occ_next;
    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance uses the registered flags as they stand before the edge.
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    always_comb begin
        occ_next = occ;
        case ({wr_ok, rd_ok})
            2'b10:   occ_next = occ + (COUNT_WIDTH + 1)'(1);
            2'b01:   occ_next = occ - (COUNT_WIDTH + 1)'(1);
            default: occ_next = occ;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            dout      <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                dout   <= mem[rd_ptr];
            end
            occ       <= occ_next;
            full      <= (occ_next == OCC_FULL);
            empty     <= (occ_next == '0);
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end

    // Wraps to 0 when full; consumers qualify with the full flag.
    assign data_count = occ[COUNT_WIDTH-1:0];

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed fill/drain/error cases plus random
// traffic, compared against a queue-based reference model.
module tb_fifo;

    logic       clk;
    logic       srst;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] dout;
    logic       full;
    logic       overflow;
    logic       empty;
    logic       underflow;
    logic [3:0] data_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] exp_dout;
    logic       exp_ov;
    logic       exp_un;

    fifo #(.DATA_WIDTH(8), .DEPTH(16), .COUNT_WIDTH(4)) dut (
        .clk        (clk),
        .srst       (srst),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .overflow   (overflow),
        .empty      (empty),
        .underflow  (underflow),
        .data_count (data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"},       {24'd0, dout},       {24'd0, exp_dout});
        chk({tag, ".full"},       {31'd0, full},       {31'd0, q.size() == 16});
        chk({tag, ".empty"},      {31'd0, empty},      {31'd0, q.size() == 0});
        chk({tag, ".overflow"},   {31'd0, overflow},   {31'd0, exp_ov});
        chk({tag, ".underflow"},  {31'd0, underflow},  {31'd0, exp_un});
        chk({tag, ".data_count"}, {28'd0, data_count}, 32'(q.size() % 16));
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = 8'd0;
        exp_ov   = 1'b0;
        exp_un   = 1'b0;
    endtask

    // Apply one cycle of requests, advance the model on the edge, then check.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
        bit was_full;
        bit was_empty;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        exp_ov = w && was_full;
        exp_un = r && was_empty;
        if (r && !was_empty) exp_dout = q.pop_front();
        if (w && !was_full)  q.push_back(d);
        #1;
        check_all(tag);
    endtask

    initial begin
        srst  = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'd0;
        model_reset();

        // Asynchronous reset asserted mid-cycle, observed before any edge.
        #2 srst = 1'b0;
        #1 check_all("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        srst = 1'b1;
        #1 check_all("reset_release");

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i * 8), "fill");
        step(1'b1, 1'b0, 8'hFF, "overflow");
        step(1'b0, 1'b0, 8'h00, "overflow_clear");
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, "drain");
        step(1'b0, 1'b1, 8'h00, "underflow");
        step(1'b0, 1'b0, 8'h00, "underflow_clear");

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), "prefill5");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'($urandom), "simul5");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "drain5");
        step(1'b1, 1'b1, 8'h5A, "simul_empty");
        step(1'b0, 1'b1, 8'h00, "read_after_simul");

        // Refill to full then do simultaneous access while full.
        while (q.size() < 16) step(1'b1, 1'b0, 8'($urandom), "refill");
        step(1'b1, 1'b1, 8'hC3, "simul_full");

        for (int i = 0; i < 400; i++) begin
            logic [1:0] mode;
            mode = 2'($urandom_range(0, 3));
            case (mode)
                2'd0: step(1'b1, 1'b0, 8'($urandom), "rand");
                2'd1: step(1'b0, 1'b1, 8'($urandom), "rand");
                2'd2: step(1'b1, 1'b1, 8'($urandom), "rand");
                default: step(1'($urandom), 1'($urandom), 8'($urandom), "rand");
            endcase
        end

        // Reset in the middle of traffic discards all stored data.
        while (q.size() < 6) step(1'b1, 1'b0, 8'($urandom), "prereset");
        #3 srst = 1'b0;
        model_reset();
        #1 check_all("reset_midop");
        @(negedge clk);
        srst = 1'b1;
        step(1'b0, 1'b1, 8'h00, "post_reset_read");
        step(1'b1, 1'b0, 8'hA5, "post_reset_write");
        step(1'b0, 1'b1, 8'h00, "post_reset_readback");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo.md
# fifo

Single-clock first-in/first-out buffer, 16 entries of 8 bits, with registered full/empty flags, one-cycle overflow/underflow error strobes and an occupancy count. It sits between a byte producer and a byte consumer in the same clock domain. Both sides use a simple enable handshake with no back-pressure beyond the status flags.

## Interface
- DATA_WIDTH, 8, width of din/dout
- DEPTH, 16, number of storage entries (power of two)
- COUNT_WIDTH, 4, width of data_count (log2 DEPTH)

- clk  input  1  clock; all state changes on the rising edge
- srst  input  1  reset, asynchronous, active-low (0 = reset asserted)
- din  input  8  write data
- wr_en  input  1  write request
- rd_en  input  1  read request
- dout  output  8  read data, registered
- full  output  1  FIFO holds DEPTH entries
- overflow  output  1  previous-cycle write was rejected
- empty  output  1  FIFO holds 0 entries
- underflow  output  1  previous-cycle read was rejected
- data_count  output  4  occupancy modulo 16

## Operation
- Storage: 16x8 array, write pointer and read pointer of 4 bits each, both wrapping 15 -> 0. The internal occupancy counter is 5 bits, range 0..16.
- Write: on a rising edge with wr_en=1 and full=0, store din at the write pointer and increment the write pointer.
- Write while full: a write with wr_en=1 and full=1 is dropped. Storage and pointers are unchanged and overflow is set for one cycle.
- Read: on a rising edge with rd_en=1 and empty=0, load dout from the read pointer and increment the read pointer.
- Read while empty: a read with rd_en=1 and empty=1 is dropped. dout holds its last value and underflow is set for one cycle.
- Flag sampling: acceptance is decided from the full/empty values present before the edge.
- Simultaneous accepted read and write: occupancy is unchanged. When empty=1, only the write is accepted and the read underflows. When full=1, only the read is accepted and the write overflows.
- Occupancy: +1 on an accepted write only, -1 on an accepted read only.
- data_count is occupancy[3:0], so it reads 0 when full. Consumers must qualify it with full.
- Flag equations: full = (occupancy==16), empty = (occupancy==0). Both are registered and updated on the same edge as the access.
- Memory contents are not reset.

## Timing
- Reset: srst=0 forces the following immediately, without waiting for a clock edge, and holds them while low:
  - dout=0, empty=1, full=0, overflow=0, underflow=0, data_count=0
  - both pointers and occupancy cleared
- Reset mid-operation discards all stored data.
- Normal operation resumes on the first rising edge after srst returns to 1.
- Write-to-flag latency: empty deasserts and data_count updates on the same edge that accepts the first write.
- Write-to-read: data written at edge N is readable by a read sampled at edge N+1 or later.
- Read latency: dout shows the new word right after the edge that accepts rd_en, i.e. one cycle after rd_en is presented.
- overflow and underflow are high for exactly the cycle following the offending edge. They stay high on consecutive edges if offending requests continue.
- Back-to-back: one write and one read may be accepted on every cycle.

## Test plan
- Reset: drive srst=0 mid-cycle with no clock edge -> all outputs go immediately to empty=1, full=0, data_count=0, dout=0, overflow=0, underflow=0.
- Fill: release reset, then assert wr_en for 16 cycles with din = i*8 (0, 8, ..., 120) -> data_count steps 1..15 then 0, full=1 after the 16th edge, empty=0 from the 1st edge.
- Overflow: hold wr_en=1 with din=0xFF on a 17th cycle while full -> overflow=1 for one cycle, full stays 1, contents unchanged.
- Drain: rd_en=1, wr_en=0 for 16 cycles -> dout = 0, 8, ..., 120 in order, one per cycle. full drops after the 1st read and empty=1 after the 16th.
- Underflow: one more read while empty -> underflow=1 for one cycle, dout holds 120, data_count=0.
- Simultaneous access: with 5 entries stored, assert wr_en and rd_en together for 4 cycles -> data_count stays 5 and reads return the oldest words in order. Repeat from empty with both asserted -> write accepted, underflow=1, data_count=1.
